// File: rtl/instr_encoder_if.sv
// Field-beat handshake and instruction-memory write port bundle.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              iValid;
  logic              oReady;
  logic [3:0]        iOpcode;
  logic [3:0]        iCDcode;
  logic              iSrcType;
  logic              iDestType;
  logic [11:0]       iSrc1;
  logic [11:0]       iSrc2;
  logic              iLast;
  logic              oMemWe;
  logic [ADDR_W-1:0] oMemAddr;
  logic [31:0]       oMemData;
  logic              iMemReady;

  // Loader / memory side
  modport master (
    output iValid, iOpcode, iCDcode, iSrcType, iDestType, iSrc1, iSrc2, iLast,
    output iMemReady,
    input  oReady, oMemWe, oMemAddr, oMemData
  );

  // Encoder side
  modport slave (
    input  iValid, iOpcode, iCDcode, iSrcType, iDestType, iSrc1, iSrc2, iLast,
    input  iMemReady,
    output oReady, oMemWe, oMemAddr, oMemData
  );
endinterface

// File: rtl/instr_encoder.sv
// Instruction encoder / program loader: packs field beats into 32-bit words,
// buffers them in a 2-entry FIFO and streams them into instruction memory,
// terminating each session with a HALT word.
module instr_encoder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] HALT_WORD = 32'hF000_0000
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iStart,
  input  logic [ADDR_W-1:0] iBaseAddr,
  instr_encoder_if.slave    bus,
  output logic              oBusy,
  output logic              oDone,
  output logic              oOverflow,
  output logic [ADDR_W:0]   oCount
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  // Highest slot a data word may occupy is DEPTH-2; reaching DEPTH-1 with
  // data still pending means the program does not fit.
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, HALT, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              last_seen_q, last_seen_d;
  logic              ovf_q, ovf_d;
  logic [1:0][31:0]  fifo_q, fifo_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        fcnt_q, fcnt_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [31:0]       word_c;
  logic              accept_c;
  logic              xfer_c;

  // Pack the incoming fields into the instruction word layout
  always_comb begin
    word_c        = '0;
    word_c[31:28] = bus.iOpcode;
    if (bus.iOpcode == 4'b0001) begin
      word_c[27:24] = bus.iCDcode;
    end else begin
      word_c[27:24] = {bus.iSrcType, bus.iDestType, 2'b00};
    end
    word_c[23:12] = bus.iSrc1;
    word_c[11:0]  = bus.iSrc2;
  end

  assign accept_c = bus.iValid && ready_q;
  assign xfer_c   = we_q && bus.iMemReady;

  // Next-state, FIFO bookkeeping and next values of the registered outputs
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    last_seen_d = last_seen_q;
    ovf_d       = ovf_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fcnt_d      = fcnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (iStart) begin
          base_d      = iBaseAddr;
          count_d     = '0;
          ovf_d       = 1'b0;
          last_seen_d = 1'b0;
          fcnt_d      = '0;
          wr_ptr_d    = 1'b0;
          rd_ptr_d    = 1'b0;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (accept_c) begin
          fifo_d[wr_ptr_q] = word_c;
          wr_ptr_d         = ~wr_ptr_q;
          if (bus.iLast) begin
            last_seen_d = 1'b1;
          end
        end
        if (xfer_c) begin
          rd_ptr_d = ~rd_ptr_q;
          count_d  = count_q + CNT_W'(1);
        end
        fcnt_d = fcnt_q + 2'(accept_c) - 2'(xfer_c);
        // Out of room: drop pending data (including any beat accepted now)
        // so the HALT word lands in the last slot.
        if ((count_d == LAST_SLOT) && (fcnt_d != 2'd0)) begin
          ovf_d       = 1'b1;
          last_seen_d = 1'b1;
          fcnt_d      = '0;
          wr_ptr_d    = 1'b0;
          rd_ptr_d    = 1'b0;
          state_d     = HALT;
        end else if (last_seen_d && (fcnt_d == 2'd0)) begin
          state_d = HALT;
        end
      end
      HALT: begin
        if (xfer_c) begin
          count_d = count_q + CNT_W'(1);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == RUN) && !last_seen_d && (fcnt_d != 2'd2);
    we_d    = ((state_d == RUN) && (fcnt_d != 2'd0)) || (state_d == HALT);
    addr_d  = base_d + count_d[ADDR_W-1:0];
    data_d  = (state_d == HALT) ? HALT_WORD : fifo_d[rd_ptr_d];
    busy_d  = (state_d == RUN) || (state_d == HALT);
    done_d  = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      last_seen_q <= 1'b0;
      ovf_q       <= 1'b0;
      fifo_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fcnt_q      <= '0;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      last_seen_q <= last_seen_d;
      ovf_q       <= ovf_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fcnt_q      <= fcnt_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.oReady   = ready_q;
  assign bus.oMemWe   = we_q;
  assign bus.oMemAddr = addr_q;
  assign bus.oMemData = data_q;
  assign oBusy        = busy_q;
  assign oDone        = done_q;
  assign oOverflow    = ovf_q;
  assign oCount       = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed beats push expected writes,
// a negedge monitor pops and compares each completed memory transfer.
module tb_instr_encoder;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] HALT_W = 32'hF000_0000;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  base;
  logic        busy, done, ovf;
  logic [8:0]  cnt;

  int n_tests = 0;
  int n_fail  = 0;
  wr_t exp_q[$];

  logic        prev_stall = 1'b0;
  logic [7:0]  prev_addr  = '0;
  logic [31:0] prev_data  = '0;

  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .HALT_WORD(HALT_W)) dut (
    .iClk      (clk),
    .iRst_n    (rst_n),
    .iStart    (start),
    .iBaseAddr (base),
    .bus       (bus),
    .oBusy     (busy),
    .oDone     (done),
    .oOverflow (ovf),
    .oCount    (cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input logic [7:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  // Monitor: compare each completed transfer and check stall stability
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (prev_stall) begin
        check("stall_addr", 32'(bus.oMemAddr), 32'(prev_addr));
        check("stall_data", bus.oMemData, prev_data);
      end
      if (bus.oMemWe && bus.iMemReady) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%02h data 0x%08h expected none",
                   bus.oMemAddr, bus.oMemData);
        end else begin
          check("wr_addr", 32'(bus.oMemAddr), 32'(exp_q[0].addr));
          check("wr_data", bus.oMemData, exp_q[0].data);
          void'(exp_q.pop_front());
        end
      end
      prev_stall <= bus.oMemWe && !bus.iMemReady;
      prev_addr  <= bus.oMemAddr;
      prev_data  <= bus.oMemData;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  // Called just after a rising edge; leaves time just after the next one
  task automatic start_session(input logic [7:0] b);
    start = 1'b1;
    base  = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic beat(input logic [3:0] op, input logic [3:0] cd, input logic st,
                      input logic dt, input logic [11:0] s1, input logic [11:0] s2,
                      input logic last, input bit may_drop);
    bit acc;
    acc              = 1'b0;
    bus.iValid       = 1'b1;
    bus.iOpcode      = op;
    bus.iCDcode      = cd;
    bus.iSrcType     = st;
    bus.iDestType    = dt;
    bus.iSrc1        = s1;
    bus.iSrc2        = s2;
    bus.iLast        = last;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (bus.oReady) acc = 1'b1;
      @(posedge clk); #1;
    end
    bus.iValid = 1'b0;
    bus.iLast  = 1'b0;
    if (!acc && !may_drop) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_timeout: got no oReady for opcode %0h expected acceptance", op);
    end
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 60 && !done; i++) @(negedge clk);
    check(name, 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    base          = '0;
    bus.iValid    = 1'b0;
    bus.iOpcode   = '0;
    bus.iCDcode   = '0;
    bus.iSrcType  = 1'b0;
    bus.iDestType = 1'b0;
    bus.iSrc1     = '0;
    bus.iSrc2     = '0;
    bus.iLast     = 1'b0;
    bus.iMemReady = 1'b1;

    // Reset values
    #12;
    check("rst_ready", 32'(bus.oReady), 32'd0);
    check("rst_we",    32'(bus.oMemWe), 32'd0);
    check("rst_addr",  32'(bus.oMemAddr), 32'd0);
    check("rst_data",  bus.oMemData, 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_ovf",   32'(ovf), 32'd0);
    check("rst_count", 32'(cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Packing, back-to-back
    push_exp(8'h30, 32'h1512_3456);
    push_exp(8'h31, 32'h28AB_C001);
    push_exp(8'h32, HALT_W);
    start_session(8'h30);
    check("ready_after_start", 32'(bus.oReady), 32'd1);
    check("busy_in_run", 32'(busy), 32'd1);
    beat(4'h1, 4'h5, 1'b0, 1'b0, 12'h123, 12'h456, 1'b0, 1'b0);
    beat(4'h2, 4'hF, 1'b1, 1'b0, 12'hABC, 12'h001, 1'b1, 1'b0);
    wait_done("done_pack");
    check("count_pack", 32'(cnt), 32'd3);
    check("busy_pack", 32'(busy), 32'd0);
    check("ovf_pack", 32'(ovf), 32'd0);

    // Backpressure
    bus.iMemReady = 1'b0;
    push_exp(8'h10, 32'h3C00_1FFF);
    push_exp(8'h11, 32'h1A7F_F800);
    push_exp(8'h12, 32'h0400_00AB);
    push_exp(8'h13, HALT_W);
    start_session(8'h10);
    beat(4'h3, 4'h0, 1'b1, 1'b1, 12'h001, 12'hFFF, 1'b0, 1'b0);
    beat(4'h1, 4'hA, 1'b0, 1'b0, 12'h7FF, 12'h800, 1'b0, 1'b0);
    check("ready_fifo_full", 32'(bus.oReady), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    bus.iMemReady = 1'b1;
    beat(4'h0, 4'h0, 1'b0, 1'b1, 12'h000, 12'h0AB, 1'b1, 1'b0);
    wait_done("done_bp");
    check("count_bp", 32'(cnt), 32'd4);
    check("ovf_bp", 32'(ovf), 32'd0);

    // Overflow at DEPTH = 4
    push_exp(8'h20, 32'h4010_0200);
    push_exp(8'h21, 32'h580F_F0EE);
    push_exp(8'h22, 32'h1311_1222);
    push_exp(8'h23, HALT_W);
    start_session(8'h20);
    beat(4'h4, 4'h0, 1'b0, 1'b0, 12'h100, 12'h200, 1'b0, 1'b0);
    beat(4'h5, 4'h0, 1'b1, 1'b0, 12'h0FF, 12'h0EE, 1'b0, 1'b0);
    beat(4'h1, 4'h3, 1'b0, 1'b0, 12'h111, 12'h222, 1'b0, 1'b0);
    beat(4'h6, 4'h0, 1'b0, 1'b0, 12'h333, 12'h444, 1'b0, 1'b1);
    beat(4'h7, 4'h0, 1'b0, 1'b0, 12'h555, 12'h666, 1'b1, 1'b1);
    wait_done("done_ovf");
    check("ovf_flag", 32'(ovf), 32'd1);
    check("count_ovf", 32'(cnt), 32'd4);

    // Wrap, restart from DONE, ignored iStart during RUN
    start_session(8'hFE);
    check("restart_done_clr", 32'(done), 32'd0);
    check("restart_count_clr", 32'(cnt), 32'd0);
    check("restart_ovf_clr", 32'(ovf), 32'd0);
    push_exp(8'hFE, 32'h84DE_AD00);
    push_exp(8'hFF, 32'h1CCA_FE00);
    push_exp(8'h00, 32'hEC00_0001);
    push_exp(8'h01, HALT_W);
    beat(4'h8, 4'h0, 1'b0, 1'b1, 12'hDEA, 12'hD00, 1'b0, 1'b0);
    start_session(8'h55);
    check("start_in_run_busy", 32'(busy), 32'd1);
    beat(4'h1, 4'hC, 1'b0, 1'b0, 12'hCAF, 12'hE00, 1'b0, 1'b0);
    beat(4'hE, 4'h0, 1'b1, 1'b1, 12'h000, 12'h001, 1'b1, 1'b0);
    wait_done("done_wrap");
    check("count_wrap", 32'(cnt), 32'd4);

    // Reset mid-session after the first write
    push_exp(8'h40, 32'h2032_1654);
    start_session(8'h40);
    beat(4'h2, 4'h0, 1'b0, 1'b0, 12'h321, 12'h654, 1'b0, 1'b0);
    beat(4'h9, 4'h0, 1'b0, 1'b0, 12'h0AA, 12'h0BB, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(bus.oReady), 32'd0);
    check("arst_we",    32'(bus.oMemWe), 32'd0);
    check("arst_addr",  32'(bus.oMemAddr), 32'd0);
    check("arst_data",  bus.oMemData, 32'd0);
    check("arst_busy",  32'(busy), 32'd0);
    check("arst_done",  32'(done), 32'd0);
    check("arst_ovf",   32'(ovf), 32'd0);
    check("arst_count", 32'(cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_exp(8'h80, 32'hF0AA_A555);
    push_exp(8'h81, HALT_W);
    start_session(8'h80);
    check("post_rst_count", 32'(cnt), 32'd0);
    beat(4'hF, 4'h0, 1'b0, 1'b0, 12'hAAA, 12'h555, 1'b1, 1'b0);
    wait_done("done_post_rst");
    check("count_post_rst", 32'(cnt), 32'd2);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
